// File: rtl/offnariscv_pkg.sv
// Shared core types: writeback result payload, source indices and width helpers.
package offnariscv_pkg;

   localparam int unsigned XLEN               = 32;
   localparam int unsigned REG_ADDR_W         = 5;
   localparam int unsigned WB_NUM_SRC_DEFAULT = 3;

   localparam int unsigned WB_SRC_ALU = 0;
   localparam int unsigned WB_SRC_LSU = 1;
   localparam int unsigned WB_SRC_CSR = 2;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  rd_we;
      logic [XLEN-1:0]       wdata;
   } wb_result_t;

   // Index width that stays at least one bit for degenerate counts
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter
   import offnariscv_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]        req,
   input  logic [idx_w(N)-1:0] ptr,
   output logic [N-1:0]        grant,
   output logic [idx_w(N)-1:0] grant_idx
);

   localparam int unsigned IW = idx_w(N);

   logic            found;
   int unsigned     pos;
   logic [IW-1:0]   pos_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = 0;
      pos_idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos     = (32'(ptr) + i) % N;
         pos_idx = IW'(pos);
         if (!found && req[pos_idx]) begin
            found          = 1'b1;
            grant[pos_idx] = 1'b1;
            grant_idx      = pos_idx;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin merge of execution-unit results into one registered stream.
// Optional retire counter enabled by defining WB_INSTRET_EN.
module wb_arbiter
   import offnariscv_pkg::*;
#(
   parameter int unsigned NUM_SRC = WB_NUM_SRC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SRC-1:0]       ex_tvalid,
   output logic [NUM_SRC-1:0]       ex_tready,
   input  wb_result_t [NUM_SRC-1:0] ex_tdata,
   output logic                     wb_tvalid,
   input  logic                     wb_tready,
   output wb_result_t               wb_tdata,
   input  logic                     invalidate,
   output logic [63:0]              retire_cnt
);

   localparam int unsigned PTR_W = idx_w(NUM_SRC);

   logic [PTR_W-1:0]   rr_ptr;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               load_en;
   logic               any_grant;
   wb_result_t         sel;

   // Requests are masked unless the output register can take a new beat
   always_comb begin
      load_en   = !wb_tvalid || wb_tready;
      req       = (rst && load_en && !invalidate) ? ex_tvalid : '0;
      any_grant = |grant;
      ex_tready = grant;
      sel       = ex_tdata[grant_idx];
      sel.rd_we = sel.rd_we && (sel.rd != '0);
   end

   rr_arbiter #(.N(NUM_SRC)) u_rr (
      .req       (req),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_tvalid <= 1'b0;
         wb_tdata  <= '0;
         rr_ptr    <= '0;
      end else begin
         if (invalidate) begin
            wb_tvalid <= 1'b0;
         end else if (any_grant) begin
            wb_tvalid <= 1'b1;
            wb_tdata  <= sel;
         end else if (wb_tready) begin
            wb_tvalid <= 1'b0;
         end
         if (any_grant) begin
            rr_ptr <= (32'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + PTR_W'(1);
         end
      end
   end

`ifdef WB_INSTRET_EN
   logic [63:0] retire_cnt_q;

   // Counts every delivered beat, including one handshaked alongside invalidate
   always_ff @(posedge clk) begin
      if (!rst) begin
         retire_cnt_q <= '0;
      end else if (wb_tvalid && wb_tready) begin
         retire_cnt_q <= retire_cnt_q + 64'd1;
      end
   end

   assign retire_cnt = retire_cnt_q;
`else
   assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, round-robin order, back-pressure, rd==0, invalidate, retire count.
module tb_wb_arbiter;
   import offnariscv_pkg::*;

   localparam int unsigned NS = 3;
`ifdef WB_INSTRET_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NS-1:0]       ex_tvalid;
   logic [NS-1:0]       ex_tready;
   wb_result_t [NS-1:0] ex_tdata;
   logic                wb_tvalid;
   logic                wb_tready;
   wb_result_t          wb_tdata;
   logic                invalidate;
   logic [63:0]         retire_cnt;

   int checks = 0;
   int errors = 0;
   int unsigned g;
   wb_result_t exp_beat;
   wb_result_t src_beat [NS];

   always #5 clk = ~clk;

   wb_arbiter #(.NUM_SRC(NS)) dut (
      .clk        (clk),
      .rst        (rst),
      .ex_tvalid  (ex_tvalid),
      .ex_tready  (ex_tready),
      .ex_tdata   (ex_tdata),
      .wb_tvalid  (wb_tvalid),
      .wb_tready  (wb_tready),
      .wb_tdata   (wb_tdata),
      .invalidate (invalidate),
      .retire_cnt (retire_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] exp_ret(input int n);
      return CNT_EN ? 64'(n) : 64'd0;
   endfunction

   initial begin
      rst        = 1'b0;
      ex_tvalid  = 3'b111;
      ex_tdata   = '0;
      wb_tready  = 1'b1;
      invalidate = 1'b0;
      for (int i = 0; i < int'(NS); i++)
         src_beat[i] = '{rd: 5'(10 + i), rd_we: 1'b1, wdata: 32'hA000_0000 + 32'(i)};

      // Reset
      repeat (3) step();
      chk("rst_tvalid", 64'(wb_tvalid), 64'd0);
      chk("rst_tdata", 64'(wb_tdata), 64'd0);
      chk("rst_tready", 64'(ex_tready), 64'd0);
      chk("rst_ptr", 64'(dut.rr_ptr), 64'd0);
      chk("rst_retire", retire_cnt, 64'd0);
      ex_tvalid = '0;
      rst       = 1'b1;
      step();

      // 1: single beat from source 0
      ex_tdata[0] = '{rd: 5'd5, rd_we: 1'b1, wdata: 32'hDEADBEEF};
      ex_tvalid   = 3'b001;
      #1;
      chk("t1_ready", 64'(ex_tready), 64'd1);
      step();
      ex_tvalid = '0;
      exp_beat  = '{rd: 5'd5, rd_we: 1'b1, wdata: 32'hDEADBEEF};
      chk("t1_tvalid", 64'(wb_tvalid), 64'd1);
      chk("t1_tdata", 64'(wb_tdata), 64'(exp_beat));
      chk("t1_ptr", 64'(dut.rr_ptr), 64'd1);
      step();
      chk("t1_drain", 64'(wb_tvalid), 64'd0);
      chk("t1_retire", retire_cnt, exp_ret(1));

      // 2: all sources valid, ptr starts at 1 -> 1,2,0,1,2,0
      for (int i = 0; i < int'(NS); i++) ex_tdata[i] = src_beat[i];
      ex_tvalid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         g = (1 + k) % NS;
         #1;
         chk("t2_grant", 64'(ex_tready), 64'(3'b001 << g));
         step();
         chk("t2_tvalid", 64'(wb_tvalid), 64'd1);
         chk("t2_tdata", 64'(wb_tdata), 64'(src_beat[g]));
      end

      // 3: back-pressure holds the source-0 beat, then source 1 follows
      wb_tready = 1'b0;
      #1;
      chk("t3_ready_bp", 64'(ex_tready), 64'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t3_hold_valid", 64'(wb_tvalid), 64'd1);
         chk("t3_hold_data", 64'(wb_tdata), 64'(src_beat[0]));
         chk("t3_hold_ready", 64'(ex_tready), 64'd0);
      end
      wb_tready = 1'b1;
      #1;
      chk("t3_resume_grant", 64'(ex_tready), 64'b010);
      step();
      chk("t3_resume_data", 64'(wb_tdata), 64'(src_beat[1]));
      ex_tvalid = '0;
      step();
      chk("t3_drain", 64'(wb_tvalid), 64'd0);
      chk("t3_retire", retire_cnt, exp_ret(8));

      // 4: rd==0 clears rd_we, still retired
      ex_tdata[2] = '{rd: 5'd0, rd_we: 1'b1, wdata: 32'h0000_1234};
      ex_tvalid   = 3'b100;
      #1;
      chk("t4_grant", 64'(ex_tready), 64'b100);
      step();
      ex_tvalid = '0;
      exp_beat  = '{rd: 5'd0, rd_we: 1'b0, wdata: 32'h0000_1234};
      chk("t4_tdata", 64'(wb_tdata), 64'(exp_beat));
      step();
      chk("t4_retire", retire_cnt, exp_ret(9));
      chk("t4_ptr", 64'(dut.rr_ptr), 64'd0);

      // 5: invalidate drops a held beat and blocks grants for one cycle
      wb_tready = 1'b0;
      ex_tvalid = 3'b001;
      step();
      chk("t5_held", 64'(wb_tvalid), 64'd1);
      ex_tvalid  = 3'b011;
      invalidate = 1'b1;
      #1;
      chk("t5_inv_ready", 64'(ex_tready), 64'd0);
      step();
      invalidate = 1'b0;
      chk("t5_inv_tvalid", 64'(wb_tvalid), 64'd0);
      chk("t5_inv_ptr", 64'(dut.rr_ptr), 64'd1);
      chk("t5_inv_retire", retire_cnt, exp_ret(9));
      #1;
      chk("t5_regrant", 64'(ex_tready), 64'b010);
      step();
      ex_tvalid = '0;
      chk("t5_regrant_data", 64'(wb_tdata), 64'(src_beat[1]));
      // handshake on the invalidate edge still counts
      wb_tready  = 1'b1;
      invalidate = 1'b1;
      step();
      invalidate = 1'b0;
      chk("t5_hs_tvalid", 64'(wb_tvalid), 64'd0);
      chk("t5_hs_retire", retire_cnt, exp_ret(10));

      // 6: retire counter wrap
      ex_tvalid = 3'b100;
      step();
      ex_tvalid = '0;
`ifdef WB_INSTRET_EN
      force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      step();
      chk("t6_wrap", retire_cnt, 64'd0);
`else
      step();
      chk("t6_tied", retire_cnt, 64'd0);
`endif

      // Reset mid-transfer loses the held beat
      ex_tvalid = 3'b001;
      wb_tready = 1'b0;
      step();
      chk("rst_mid_pre", 64'(wb_tvalid), 64'd1);
      rst = 1'b0;
      step();
      chk("rst_mid_tvalid", 64'(wb_tvalid), 64'd0);
      chk("rst_mid_ready", 64'(ex_tready), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
